// File: rtl/regfile_sb_if.sv
// Register file bus: read ports, two writeback ports and issue port.
// The master drives addresses and writes; the slave returns data and busy.
interface regfile_sb_if #(
    parameter int XLEN = 64,
    parameter int AW   = 5
);
    logic            ready;
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            wen0;
    logic [AW-1:0]   rd0;
    logic [XLEN-1:0] wdata0;
    logic            wen1;
    logic [AW-1:0]   rd1;
    logic [XLEN-1:0] wdata1;
    logic            iss_en;
    logic [AW-1:0]   iss_rd;

    modport master (
        input  ready, src1, src2, rs1_busy, rs2_busy,
        output rs1, rs2, wen0, rd0, wdata0,
        output wen1, rd1, wdata1, iss_en, iss_rd
    );

    modport slave (
        output ready, src1, src2, rs1_busy, rs2_busy,
        input  rs1, rs2, wen0, rd0, wdata0,
        input  wen1, rd1, wdata1, iss_en, iss_rd
    );
endinterface

// File: rtl/regfile_sb.sv
// Two-write/two-read register file with issue scoreboard.
// Clears every entry after reset before accepting traffic.
module regfile_sb #(
    parameter int XLEN   = 64,
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     cnt_q;
    logic [AW-1:0]     cnt_d;
    logic [XLEN-1:0]   regs_q [NREG];
    logic [NREG-1:0]   busy_q;
    logic              run;
    logic              w0;
    logic              w1;
    logic              iss;

    assign run = (state_q == RUN);
    assign w0  = run && bus.wen0 && (bus.rd0 != '0);
    assign w1  = run && bus.wen1 && (bus.rd1 != '0);
    assign iss = run && bus.iss_en && (bus.iss_rd != '0);

    // FSM state and init counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Walk the clear index through every entry, then go live
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(NREG - 1)) begin
                state_d = RUN;
            end
        end
    end

    // Data array: clear during INIT, port 1 wins on a shared target
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                regs_q[cnt_q] <= '0;
            end else begin
                if (w0) regs_q[bus.rd0] <= bus.wdata0;
                if (w1) regs_q[bus.rd1] <= bus.wdata1;
            end
        end
    end

    // Scoreboard: writeback clears, a same-cycle issue sets last
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == INIT) begin
                busy_q[cnt_q] <= 1'b0;
            end else begin
                if (w0)  busy_q[bus.rd0]    <= 1'b0;
                if (w1)  busy_q[bus.rd1]    <= 1'b0;
                if (iss) busy_q[bus.iss_rd] <= 1'b1;
            end
        end
    end

    function automatic logic [XLEN-1:0] rd_data(
        input logic [AW-1:0] rs
    );
        logic [XLEN-1:0] d;
        d = regs_q[rs];
        if (BYPASS != 0 && w0 && bus.rd0 == rs) d = bus.wdata0;
        if (BYPASS != 0 && w1 && bus.rd1 == rs) d = bus.wdata1;
        if (!run || rs == '0) d = '0;
        return d;
    endfunction

    function automatic logic rd_busy(
        input logic [AW-1:0] rs
    );
        logic b;
        b = busy_q[rs];
        if (BYPASS != 0 && w0 && bus.rd0 == rs) b = 1'b0;
        if (BYPASS != 0 && w1 && bus.rd1 == rs) b = 1'b0;
        if (!run || rs == '0) b = 1'b0;
        return b;
    endfunction

    // Combinational read ports with optional forwarding
    always_comb begin
        bus.src1     = rd_data(bus.rs1);
        bus.src2     = rd_data(bus.rs2);
        bus.rs1_busy = rd_busy(bus.rs1);
        bus.rs2_busy = rd_busy(bus.rs2);
    end

    assign bus.ready = run;

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: bypassed and non-bypassed copies share stimulus
// and are compared against a cycle-level reference model.
module tb_regfile_sb;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb_if #(.XLEN(XLEN), .AW(AW)) b1 ();
    regfile_sb_if #(.XLEN(XLEN), .AW(AW)) b0 ();

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .BYPASS(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    always #5 clk = ~clk;

    logic            t_wen0, t_wen1, t_iss;
    logic [AW-1:0]   t_rd0, t_rd1, t_iss_rd, t_rs1, t_rs2;
    logic [XLEN-1:0] t_wd0, t_wd1;

    bit              mrun;
    int              icnt;
    logic [XLEN-1:0] mreg [NREG];
    bit              mbusy [NREG];

    task automatic apply();
        b1.wen0 = t_wen0; b0.wen0 = t_wen0;
        b1.rd0 = t_rd0; b0.rd0 = t_rd0;
        b1.wdata0 = t_wd0; b0.wdata0 = t_wd0;
        b1.wen1 = t_wen1; b0.wen1 = t_wen1;
        b1.rd1 = t_rd1; b0.rd1 = t_rd1;
        b1.wdata1 = t_wd1; b0.wdata1 = t_wd1;
        b1.iss_en = t_iss; b0.iss_en = t_iss;
        b1.iss_rd = t_iss_rd; b0.iss_rd = t_iss_rd;
        b1.rs1 = t_rs1; b0.rs1 = t_rs1;
        b1.rs2 = t_rs2; b0.rs2 = t_rs2;
    endtask

    task automatic idle();
        t_wen0 = 0; t_wen1 = 0; t_iss = 0;
        t_rd0 = 0; t_rd1 = 0; t_iss_rd = 0;
        t_wd0 = 0; t_wd1 = 0;
        t_rs1 = 0; t_rs2 = 0;
        apply();
    endtask

    task automatic model_step();
        if (rst) begin
            mrun = 0;
            icnt = 0;
        end else if (!mrun) begin
            mreg[icnt]  = '0;
            mbusy[icnt] = 0;
            icnt++;
            if (icnt == NREG) mrun = 1;
        end else begin
            if (t_wen0 && t_rd0 != 0) begin
                mreg[t_rd0] = t_wd0;
                mbusy[t_rd0] = 0;
            end
            if (t_wen1 && t_rd1 != 0) begin
                mreg[t_rd1] = t_wd1;
                mbusy[t_rd1] = 0;
            end
            if (t_iss && t_iss_rd != 0) mbusy[t_iss_rd] = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    function automatic logic [XLEN-1:0] exp_src(
        input logic [AW-1:0] rs, input bit byp
    );
        if (!mrun || rs == 0) return '0;
        if (byp && t_wen1 && t_rd1 == rs) return t_wd1;
        if (byp && t_wen0 && t_rd0 == rs) return t_wd0;
        return mreg[rs];
    endfunction

    function automatic logic exp_busy(
        input logic [AW-1:0] rs, input bit byp
    );
        bit hit;
        if (!mrun || rs == 0) return 1'b0;
        hit = (t_wen0 && t_rd0 == rs) || (t_wen1 && t_rd1 == rs);
        if (byp && hit) return 1'b0;
        return mbusy[rs];
    endfunction

    // Counts NREG cycles of ready=0 with traffic ignored, then ready=1.
    task automatic init_window(input string tag);
        for (int i = 0; i < NREG; i++) begin
            t_wen0 = 1; t_rd0 = AW'(i); t_wd0 = 64'hDEAD;
            t_iss = 1; t_iss_rd = AW'(i);
            t_rs1 = AW'(i); t_rs2 = AW'(NREG - 1 - i);
            apply();
            #1;
            n_checks++;
            if (b1.ready !== 1'b0 || b0.ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_ready_low cyc=%0d got=%b/%b want=0",
                         tag, i, b1.ready, b0.ready);
            end
            n_checks++;
            if (b1.src1 !== '0 || b1.src2 !== '0 || b1.rs1_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_init_read cyc=%0d got=%h/%h/%b want=0",
                         tag, i, b1.src1, b1.src2, b1.rs1_busy);
            end
            tick();
        end
        idle();
        #1;
        n_checks++;
        if (b1.ready !== 1'b1 || b0.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_ready_high got=%b/%b want=1",
                     tag, b1.ready, b0.ready);
        end
    endtask

    task automatic test_reset();
        idle();
        rst = 1;
        tick();
        tick();
        n_checks++;
        if (b1.ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready got=%b want=0", b1.ready);
        end
        rst = 0;
        init_window("reset");
        for (int i = 0; i < NREG; i++) begin
            t_rs1 = AW'(i); t_rs2 = AW'(NREG - 1 - i);
            apply();
            #1;
            n_checks++;
            if (b1.src1 !== '0 || b1.src2 !== '0 ||
                b0.src1 !== '0 || b0.src2 !== '0 ||
                b1.rs1_busy !== 1'b0 || b0.rs2_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_clear idx=%0d got=%h/%h want=0",
                         i, b1.src1, b0.src2);
            end
        end
        idle();
    endtask

    task automatic test_bypass();
        idle();
        t_wen0 = 1; t_rd0 = 5; t_wd0 = 64'h1234; t_rs1 = 5;
        apply();
        #1;
        n_checks++;
        if (b1.src1 !== 64'h1234) begin
            n_fail++;
            $display("FAIL bypass_same got=%h want=1234", b1.src1);
        end
        n_checks++;
        if (b0.src1 !== 64'h0) begin
            n_fail++;
            $display("FAIL nobypass_same got=%h want=0", b0.src1);
        end
        tick();
        idle();
        t_rs1 = 5;
        apply();
        #1;
        n_checks++;
        if (b1.src1 !== 64'h1234 || b0.src1 !== 64'h1234) begin
            n_fail++;
            $display("FAIL bypass_next got=%h/%h want=1234",
                     b1.src1, b0.src1);
        end
        idle();
    endtask

    task automatic test_collision();
        idle();
        t_wen0 = 1; t_rd0 = 7; t_wd0 = 64'hAA;
        t_wen1 = 1; t_rd1 = 7; t_wd1 = 64'hBB;
        t_rs1 = 7;
        apply();
        #1;
        n_checks++;
        if (b1.src1 !== 64'hBB) begin
            n_fail++;
            $display("FAIL collide_bypass got=%h want=bb", b1.src1);
        end
        tick();
        idle();
        t_rs2 = 7;
        apply();
        #1;
        n_checks++;
        if (b1.src2 !== 64'hBB || b0.src2 !== 64'hBB) begin
            n_fail++;
            $display("FAIL collide_store got=%h/%h want=bb",
                     b1.src2, b0.src2);
        end
        idle();
    endtask

    task automatic test_x0();
        idle();
        t_wen0 = 1; t_rd0 = 0; t_wd0 = 64'hFFFF;
        t_iss = 1; t_iss_rd = 0; t_rs2 = 0;
        apply();
        #1;
        n_checks++;
        if (b1.src2 !== '0 || b1.rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_same got=%h/%b want=0/0",
                     b1.src2, b1.rs2_busy);
        end
        tick();
        idle();
        apply();
        #1;
        n_checks++;
        if (b1.src2 !== '0 || b0.src2 !== '0 ||
            b1.rs2_busy !== 1'b0 || b0.rs2_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_after got=%h/%h want=0", b1.src2, b0.src2);
        end
    endtask

    task automatic test_scoreboard();
        idle();
        t_iss = 1; t_iss_rd = 3;
        apply();
        tick();
        idle();
        t_rs1 = 3;
        apply();
        #1;
        n_checks++;
        if (b1.rs1_busy !== 1'b1 || b0.rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_set got=%b/%b want=1",
                     b1.rs1_busy, b0.rs1_busy);
        end
        t_iss = 1; t_iss_rd = 3;
        t_wen1 = 1; t_rd1 = 3; t_wd1 = 64'd9;
        apply();
        #1;
        n_checks++;
        if (b1.rs1_busy !== 1'b0 || b0.rs1_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_fwd_clear got=%b/%b want=0/1",
                     b1.rs1_busy, b0.rs1_busy);
        end
        tick();
        idle();
        t_rs1 = 3;
        apply();
        #1;
        n_checks++;
        if (b1.rs1_busy !== 1'b1 || b1.src1 !== 64'd9 ||
            b0.src1 !== 64'd9) begin
            n_fail++;
            $display("FAIL sb_set_wins got=%b/%h want=1/9",
                     b1.rs1_busy, b1.src1);
        end
        t_wen1 = 1; t_rd1 = 3; t_wd1 = 64'd9;
        apply();
        tick();
        idle();
        t_rs1 = 3;
        apply();
        #1;
        n_checks++;
        if (b1.rs1_busy !== 1'b0 || b0.rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL sb_clear got=%b/%b want=0",
                     b1.rs1_busy, b0.rs1_busy);
        end
        idle();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            t_wen0 = 1'($urandom_range(0, 1));
            t_wen1 = 1'($urandom_range(0, 1));
            t_iss = 1'($urandom_range(0, 1));
            t_rd0 = AW'($urandom_range(0, 7));
            t_rd1 = AW'($urandom_range(0, 7));
            t_iss_rd = AW'($urandom_range(0, 7));
            t_rs1 = AW'($urandom_range(0, 7));
            t_rs2 = AW'($urandom_range(0, NREG - 1));
            t_wd0 = {$urandom, $urandom};
            t_wd1 = {$urandom, $urandom};
            apply();
            #1;
            n_checks++;
            if (b1.src1 !== exp_src(t_rs1, 1) ||
                b1.src2 !== exp_src(t_rs2, 1)) begin
                n_fail++;
                $display("FAIL rand_src_byp n=%0d got=%h/%h want=%h/%h",
                         n, b1.src1, b1.src2,
                         exp_src(t_rs1, 1), exp_src(t_rs2, 1));
            end
            n_checks++;
            if (b0.src1 !== exp_src(t_rs1, 0) ||
                b0.src2 !== exp_src(t_rs2, 0)) begin
                n_fail++;
                $display("FAIL rand_src_nobyp n=%0d got=%h/%h want=%h/%h",
                         n, b0.src1, b0.src2,
                         exp_src(t_rs1, 0), exp_src(t_rs2, 0));
            end
            n_checks++;
            if (b1.rs1_busy !== exp_busy(t_rs1, 1) ||
                b1.rs2_busy !== exp_busy(t_rs2, 1) ||
                b0.rs1_busy !== exp_busy(t_rs1, 0) ||
                b0.rs2_busy !== exp_busy(t_rs2, 0)) begin
                n_fail++;
                $display("FAIL rand_busy n=%0d got=%b%b%b%b want=%b%b%b%b",
                         n, b1.rs1_busy, b1.rs2_busy,
                         b0.rs1_busy, b0.rs2_busy,
                         exp_busy(t_rs1, 1), exp_busy(t_rs2, 1),
                         exp_busy(t_rs1, 0), exp_busy(t_rs2, 0));
            end
            tick();
        end
        idle();
    endtask

    task automatic test_reset_mid_init();
        idle();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 10; i++) tick();
        rst = 1;
        tick();
        rst = 0;
        init_window("midinit");
    endtask

    task automatic test_reset_mid_run();
        idle();
        t_wen0 = 1; t_rd0 = 9; t_wd0 = 64'h55;
        apply();
        tick();
        t_wen1 = 1; t_rd1 = 9; t_wd1 = 64'h66;
        t_iss = 1; t_iss_rd = 9;
        rst = 1;
        apply();
        tick();
        rst = 0;
        init_window("midrun");
        t_rs1 = 9;
        apply();
        #1;
        n_checks++;
        if (b1.src1 !== 64'h0 || b0.src1 !== 64'h0 ||
            b1.rs1_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrun_cleared got=%h/%h/%b want=0",
                     b1.src1, b0.src1, b1.rs1_busy);
        end
        idle();
    endtask

    initial begin
        mrun = 0;
        icnt = 0;
        test_reset();
        test_bypass();
        test_collision();
        test_x0();
        test_scoreboard();
        test_random();
        test_reset_mid_init();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
